// File: rtl/shared_mem_arbiter_if.sv
// Bundles the host, core and memory-side signals of the shared data RAM arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment
// (host sequencer, cores and RAM) that drives requests and read data.
interface shared_mem_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
);
  logic                          host_req;
  logic                          host_we;
  logic [ADDR_W-1:0]             host_addr;
  logic [DATA_W-1:0]             host_wdata;
  logic                          host_gnt;
  logic                          host_rvalid;
  logic [NUM_CORES-1:0]          core_req;
  logic [NUM_CORES-1:0]          core_we;
  logic [NUM_CORES*ADDR_W-1:0]   core_addr;
  logic [NUM_CORES*DATA_W-1:0]   core_wdata;
  logic [NUM_CORES-1:0]          core_gnt;
  logic [NUM_CORES-1:0]          core_rvalid;
  logic                          mem_en;
  logic                          mem_we;
  logic [ADDR_W-1:0]             mem_addr;
  logic [DATA_W-1:0]             mem_wdata;
  logic [DATA_W-1:0]             mem_rdata;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    input  core_req, core_we, core_addr, core_wdata,
    input  mem_rdata,
    output host_gnt, host_rvalid, core_gnt, core_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    output core_req, core_we, core_addr, core_wdata,
    output mem_rdata,
    input  host_gnt, host_rvalid, core_gnt, core_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/shared_mem_arbiter.sv
// Shares one single-port data RAM between the host port (absolute priority)
// and NUM_CORES cores served round-robin, one registered access per cycle.
// Read data is passed straight through; a registered tag raises the matching
// rvalid in the cycle the RAM presents the data.
module shared_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shared_mem_arbiter_if.slave  bus
);
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [PTR_W-1:0]     rr_ptr_q,      rr_ptr_d;
  logic [NUM_CORES-1:0] core_gnt_q,    core_gnt_d;
  logic                 host_gnt_q,    host_gnt_d;
  logic                 mem_en_q,      mem_en_d;
  logic                 mem_we_q,      mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q,    mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q,   mem_wdata_d;
  logic                 host_rvalid_q, host_rvalid_d;
  logic [NUM_CORES-1:0] core_rvalid_q, core_rvalid_d;

  logic [ADDR_W-1:0]    core_addr_w  [NUM_CORES];
  logic [DATA_W-1:0]    core_wdata_w [NUM_CORES];
  logic [NUM_CORES-1:0] eligible;
  logic [PTR_W-1:0]     win;
  logic                 found;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
      assign core_addr_w[gi]  = bus.core_addr[gi*ADDR_W +: ADDR_W];
      assign core_wdata_w[gi] = bus.core_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // A core granted this cycle is masked so a held request cannot win twice in a row.
  assign eligible = bus.core_req & ~core_gnt_q;

  // Pick the first eligible core at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!found && eligible[PTR_W'(idx)]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  // Next memory command, grants and read tags; idle cycles drive all-zero mem fields.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    core_gnt_d    = '0;
    host_gnt_d    = 1'b0;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = '0;
    mem_wdata_d   = '0;
    // The read issued this cycle returns data next cycle to whoever owns it now,
    // regardless of who wins the next arbitration.
    host_rvalid_d = host_gnt_q & ~mem_we_q;
    core_rvalid_d = mem_we_q ? '0 : core_gnt_q;
    if (bus.host_req) begin
      host_gnt_d  = 1'b1;
      mem_en_d    = 1'b1;
      mem_we_d    = bus.host_we;
      mem_addr_d  = bus.host_addr;
      mem_wdata_d = bus.host_wdata;
    end else if (found) begin
      core_gnt_d  = {{(NUM_CORES-1){1'b0}}, 1'b1} << win;
      mem_en_d    = 1'b1;
      mem_we_d    = bus.core_we[win];
      mem_addr_d  = core_addr_w[win];
      mem_wdata_d = core_wdata_w[win];
      rr_ptr_d    = (int'(win) == NUM_CORES - 1) ? '0 : win + PTR_W'(1);
    end
  end

  // State and registered outputs; reset drops every output and pending read tag at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      core_gnt_q    <= '0;
      host_gnt_q    <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      host_rvalid_q <= 1'b0;
      core_rvalid_q <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      core_gnt_q    <= core_gnt_d;
      host_gnt_q    <= host_gnt_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      host_rvalid_q <= host_rvalid_d;
      core_rvalid_q <= core_rvalid_d;
    end
  end

  assign bus.host_gnt    = host_gnt_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.core_gnt    = core_gnt_q;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: reset, round-robin fairness, lone
// reader, host override, core write, read interleaving and pointer wrap.
module tb_shared_mem_arbiter;
  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  shared_mem_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

  shared_mem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    bus.core_we[i]              = we;
    bus.core_addr[i*AW +: AW]   = addr;
    bus.core_wdata[i*DW +: DW]  = wdata;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n          = 1'b0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.core_req   = '0;
    bus.core_we    = '0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.mem_rdata  = 16'hA5A5;
    for (int i = 0; i < NC; i++) set_core(i, 1'b0, 16'h0100 + 16'(i), 16'h0);

    // Reset state
    tick();
    tick();
    chk("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("rst_host_gnt", {31'b0, bus.host_gnt}, 32'd0);
    chk("rst_core_gnt", {28'b0, bus.core_gnt}, 32'd0);
    chk("rst_core_rvalid", {28'b0, bus.core_rvalid}, 32'd0);

    // T2 fairness: all four cores reading, held
    @(negedge clk);
    rst_n = 1'b1;
    bus.core_req = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("fair_gnt_%0d", i), {28'b0, bus.core_gnt}, 32'(1 << (i % 4)));
      chk($sformatf("fair_addr_%0d", i), {16'b0, bus.mem_addr}, 32'h0100 + 32'(i % 4));
      chk($sformatf("fair_rvalid_%0d", i), {28'b0, bus.core_rvalid},
          (i == 0) ? 32'd0 : 32'(1 << ((i - 1) % 4)));
    end

    // T1 reset mid-stream: outputs clear immediately
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("midrst_core_gnt", {28'b0, bus.core_gnt}, 32'd0);
    chk("midrst_core_rvalid", {28'b0, bus.core_rvalid}, 32'd0);
    chk("midrst_host_rvalid", {31'b0, bus.host_rvalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("postrst_gnt", {28'b0, bus.core_gnt}, 32'h1);
    chk("postrst_rvalid", {28'b0, bus.core_rvalid}, 32'h0);
    tick();
    chk("postrst_gnt2", {28'b0, bus.core_gnt}, 32'h2);
    chk("postrst_rvalid2", {28'b0, bus.core_rvalid}, 32'h1);
    bus.core_req = 4'h0;
    tick();
    chk("idle_mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("idle_mem_addr", {16'b0, bus.mem_addr}, 32'd0);
    chk("idle_rvalid", {28'b0, bus.core_rvalid}, 32'h2);
    tick();
    chk("idle_rvalid2", {28'b0, bus.core_rvalid}, 32'h0);

    // T3 lone reader: core 2, addr 0x0010, request held
    set_core(2, 1'b0, 16'h0010, 16'h0);
    bus.core_req = 4'h4;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("lone_gnt_%0d", i), {28'b0, bus.core_gnt}, (i % 2 == 0) ? 32'h4 : 32'h0);
      chk($sformatf("lone_rvalid_%0d", i), {28'b0, bus.core_rvalid}, (i % 2 == 1) ? 32'h4 : 32'h0);
      if (i % 2 == 0)
        chk($sformatf("lone_addr_%0d", i), {16'b0, bus.mem_addr}, 32'h0010);
    end
    bus.core_req = 4'h0;

    // T4 host override: cores 1 and 3 waiting, host writes addr 0..7
    bus.core_req = 4'hA;
    bus.host_req = 1'b1;
    bus.host_we  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.host_addr  = 16'(i);
      bus.host_wdata = 16'h1000 + 16'(i);
      tick();
      chk($sformatf("host_gnt_%0d", i), {31'b0, bus.host_gnt}, 32'd1);
      chk($sformatf("host_addr_%0d", i), {16'b0, bus.mem_addr}, 32'(i));
      chk($sformatf("host_core_gnt_%0d", i), {28'b0, bus.core_gnt}, 32'd0);
    end
    bus.host_req = 1'b0;
    bus.host_we  = 1'b0;
    tick();
    chk("after_host_gnt", {28'b0, bus.core_gnt}, 32'h8);
    chk("after_host_hgnt", {31'b0, bus.host_gnt}, 32'd0);
    chk("after_host_hrvalid", {31'b0, bus.host_rvalid}, 32'd0);
    bus.core_req = 4'h2;
    tick();
    chk("after_host_gnt2", {28'b0, bus.core_gnt}, 32'h2);
    chk("after_host_rvalid2", {28'b0, bus.core_rvalid}, 32'h8);
    bus.core_req = 4'h0;
    tick();
    chk("after_host_rvalid3", {28'b0, bus.core_rvalid}, 32'h2);

    // T5 write: core 0 writes 0xBEEF to 0x0005
    set_core(0, 1'b1, 16'h0005, 16'hBEEF);
    bus.core_req = 4'h1;
    tick();
    chk("wr_gnt", {28'b0, bus.core_gnt}, 32'h1);
    chk("wr_en", {31'b0, bus.mem_en}, 32'd1);
    chk("wr_we", {31'b0, bus.mem_we}, 32'd1);
    chk("wr_addr", {16'b0, bus.mem_addr}, 32'h0005);
    chk("wr_wdata", {16'b0, bus.mem_wdata}, 32'hBEEF);
    bus.core_req = 4'h0;
    tick();
    chk("wr_no_rvalid", {28'b0, bus.core_rvalid}, 32'h0);
    chk("wr_idle_we", {31'b0, bus.mem_we}, 32'd0);
    chk("wr_idle_wdata", {16'b0, bus.mem_wdata}, 32'd0);

    // Interleave: core 0 read, then host read takes the next cycle
    set_core(0, 1'b0, 16'h0100, 16'h0);
    bus.core_req = 4'h1;
    tick();
    chk("il_core_gnt", {28'b0, bus.core_gnt}, 32'h1);
    bus.core_req  = 4'h0;
    bus.host_req  = 1'b1;
    bus.host_addr = 16'h0055;
    tick();
    chk("il_host_gnt", {31'b0, bus.host_gnt}, 32'd1);
    chk("il_core_rvalid", {28'b0, bus.core_rvalid}, 32'h1);
    chk("il_host_rvalid0", {31'b0, bus.host_rvalid}, 32'd0);
    bus.host_req = 1'b0;
    tick();
    chk("il_host_rvalid1", {31'b0, bus.host_rvalid}, 32'd1);
    chk("il_core_rvalid1", {28'b0, bus.core_rvalid}, 32'h0);
    tick();
    chk("il_host_rvalid2", {31'b0, bus.host_rvalid}, 32'd0);

    // T6 wrap: move rr_ptr to 3 via core 2, then cores 0 and 3 together
    bus.core_req = 4'h4;
    tick();
    chk("wrap_pre_gnt", {28'b0, bus.core_gnt}, 32'h4);
    bus.core_req = 4'h0;
    tick();
    bus.core_req = 4'h9;
    tick();
    chk("wrap_gnt3", {28'b0, bus.core_gnt}, 32'h8);
    bus.core_req = 4'h1;
    tick();
    chk("wrap_gnt0", {28'b0, bus.core_gnt}, 32'h1);
    bus.core_req = 4'h3;
    tick();
    chk("wrap_ptr1", {28'b0, bus.core_gnt}, 32'h2);
    bus.core_req = 4'h1;
    tick();
    chk("wrap_last", {28'b0, bus.core_gnt}, 32'h1);
    bus.core_req = 4'h0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
